pipeline_control: RTL and testbench
===================================

# pipeline_control

Hazard and sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it decides, per pipeline register, whether to hold, capture, or capture a bubble, and whether the PC advances. The decision comes from instruction-cache and data-cache handshakes, load-use hazards, taken branches resolved in MEM, jumps in ID and halt. It owns the halt drain sequence and two saturating performance counters. It sits beside the datapath and drives only control lines.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock. One clock domain only.
- nRST  in  1  reset. Asynchronous, active-low.
- ihit  in  1  instruction fetch for the current PC is complete this cycle.
- dhit  in  1  data access of the MEM-stage instruction is complete this cycle.
- mem_dren, mem_dwen  in  1  MEM-stage instruction reads or writes data memory.
- ex_dren  in  1  EX-stage instruction is a load.
- ex_rt  in  5  destination register of the EX-stage load.
- id_rs, id_rt  in  5  source registers of the ID-stage instruction.
- id_uses_rt  in  1  the ID-stage instruction reads rt as a source.
- id_jump  in  1  ID-stage instruction is J, JAL or JR.
- id_halt  in  1  ID-stage instruction is HALT.
- mem_brtaken  in  1  branch in MEM resolved as taken.
- wb_halt  in  1  HALT instruction is in WB.
- pc_en  out  1  PC loads its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline register captures its input.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  when the matching enable is 1, the register captures a bubble (all control fields 0). Ignored when the enable is 0.
- halt  out  1  processor halted. Sticky until reset.
- stall_cnt  out  CNT_W  number of cycles with pc_en=0 in RUN or DRAIN.
- flush_cnt  out  CNT_W  number of taken-branch flushes.

## Operation
Definitions:
- dreq = mem_dren | mem_dwen.
- lu = ex_dren & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).

FSM states: RUN, DRAIN, HALTED. Rules are evaluated in RUN and DRAIN, in priority order; the first match wins.
1. dreq & !dhit: freeze.
   - pc_en, ifid_en, idex_en, exmem_en = 0.
   - memwb_en=1, memwb_flush=1, so no duplicate writeback occurs.
2. dreq & dhit & !ihit: partial advance.
   - memwb_en=1; exmem_en=1 with exmem_flush=1.
   - idex_en, ifid_en, pc_en = 0.
3. mem_brtaken: all enables 1, pc_en=1.
   - ifid_flush, idex_flush, exmem_flush = 1.
   - This rule does not wait for ihit.
   - In DRAIN, the next state is RUN (the HALT was on the wrong path).
4. lu: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1. exmem and memwb advance.
5. !ihit: pc_en=0; ifid_en=1 with ifid_flush=1. The rest of the pipeline advances.
6. Otherwise: full advance. All enables 1, pc_en=1.
   - ifid_flush = id_jump.

Halt handling:
- In RUN, if id_halt is set when rule 5 or 6 fires: next state is DRAIN.
- In DRAIN, rules 1–4 apply unchanged. In place of rules 5 and 6: pc_en=0 and ifid_en=1 with ifid_flush=1 regardless of ihit; idex, exmem and memwb advance.
- In DRAIN, wb_halt moves the FSM to HALTED. In RUN, wb_halt also moves the FSM to HALTED.
- HALTED: all enables and flushes are 0, and halt=1.
- Only reset leaves HALTED.

Counters:
- stall_cnt increments in RUN or DRAIN whenever pc_en=0.
- flush_cnt increments on each rule-3 cycle.
- Both counters saturate at 2^CNT_W−1.

## Timing
- All control outputs are combinational from the inputs and the registered state, and valid in the same cycle.
- halt and the counters are registered, with 1-cycle latency.
- Reset values: state=RUN, halt=0, both counters=0.
- While nRST=0, every enable and flush output is 0.
- Asserting reset mid-stall or mid-drain aborts immediately to RUN.
- A load-use hazard costs exactly 1 bubble once ihit is present.
- A taken branch costs 3 squashed slots.
- dhit and ihit in the same cycle produce a full advance (rule 6).
- mem_brtaken together with lu: rule 3 wins, because the ID instruction is squashed.
- id_halt together with id_jump: DRAIN is entered and ifid is flushed.
- Entering HALTED happens in the cycle after wb_halt.

## Structure
- cpu_types_pkg gains pctl_state_t (RUN, DRAIN, HALTED, 2-bit enum).
- regbits_t from the package is used for all register-number ports.
- One sub-module, sat_counter (parameter W; inputs CLK, nRST, inc; output count), instantiated twice.
- Natural size is about 200 lines including sat_counter.

## Test plan
- Load-use: lw $2 in EX and add $3,$2,$4 in ID with ihit=1 → for 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0→1. With ex_rt=0 there is no stall.
- D-miss: mem_dren=1 and dhit=0 for 4 cycles, then dhit=1 with ihit=0, then ihit=1 → 4 freeze cycles (memwb bubble), then 1 partial-advance cycle, then a full advance.
- Branch: mem_brtaken=1 with ihit=0 → pc_en=1 and all three flushes = 1; flush_cnt goes 0→1.
- Halt: id_halt=1 with ihit → DRAIN, then 3 cycles of pc_en=0 with ifid flush, then wb_halt=1 → halt=1 next cycle; later stimulus leaves all enables at 0.
- Wrong-path halt: in DRAIN, mem_brtaken=1 → flushes asserted, and the state returns to RUN (pc_en=1 on the next ihit).
- Reset mid-DRAIN with CNT_W=4 and stall_cnt preloaded to 15 by 20 stall cycles → the counter stays at 15 until reset; after nRST falls all outputs are 0 and the state is RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register numbers, pipeline-control FSM states and the
// per-register control bundle driven by pipeline_control.
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pctl_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } pctl_ctrl_t;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   function automatic logic load_use(input logic     ex_dren,
                                     input regbits_t ex_rt,
                                     input regbits_t id_rs,
                                     input regbits_t id_rt,
                                     input logic     id_uses_rt);
      return ex_dren && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}}))
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Hazard/sequencing controller: per-cycle hold/capture/bubble decisions for the
// pipeline registers and PC, halt drain FSM, and stall/flush statistics.
module pipeline_control
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             ex_dren,
   input  regbits_t         ex_rt,
   input  regbits_t         id_rs,
   input  regbits_t         id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             id_halt,
   input  logic             mem_brtaken,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pctl_state_t state_q, state_d;
   pctl_ctrl_t  ctrl, ctrl_gated;
   logic        dreq;
   logic        lu;
   logic        active;
   logic        flush_inc;
   logic        stall_inc;

   assign dreq   = mem_dren | mem_dwen;
   assign lu     = load_use(ex_dren, ex_rt, id_rs, id_rt, id_uses_rt);
   assign active = (state_q != HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      ctrl      = '0;
      state_d   = state_q;
      flush_inc = 1'b0;
      if (active) begin
         if (dreq && !dhit) begin
            // Bubble into MEM/WB so the stalled instruction is not written back twice.
            ctrl.memwb_en    = 1'b1;
            ctrl.memwb_flush = 1'b1;
         end else if (dreq && !ihit) begin
            ctrl.memwb_en    = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.exmem_flush = 1'b1;
         end else if (mem_brtaken) begin
            ctrl.pc_en       = 1'b1;
            ctrl.ifid_en     = 1'b1;
            ctrl.idex_en     = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.memwb_en    = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            flush_inc        = 1'b1;
            // A HALT being drained sat on the wrong path of this branch.
            state_d          = RUN;
         end else if (lu) begin
            ctrl.idex_en     = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.memwb_en    = 1'b1;
         end else if (!ihit || (state_q == DRAIN)) begin
            ctrl.ifid_en     = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_en     = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.memwb_en    = 1'b1;
            if (id_halt)
               state_d = DRAIN;
         end else begin
            ctrl.pc_en       = 1'b1;
            ctrl.ifid_en     = 1'b1;
            ctrl.idex_en     = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.memwb_en    = 1'b1;
            ctrl.ifid_flush  = id_jump;
            if (id_halt)
               state_d = DRAIN;
         end
         if (wb_halt)
            state_d = HALTED;
      end
   end

   // Hold every control line low for the whole time reset is asserted.
   assign ctrl_gated  = nRST ? ctrl : '0;

   assign pc_en       = ctrl_gated.pc_en;
   assign ifid_en     = ctrl_gated.ifid_en;
   assign idex_en     = ctrl_gated.idex_en;
   assign exmem_en    = ctrl_gated.exmem_en;
   assign memwb_en    = ctrl_gated.memwb_en;
   assign ifid_flush  = ctrl_gated.ifid_flush;
   assign idex_flush  = ctrl_gated.idex_flush;
   assign exmem_flush = ctrl_gated.exmem_flush;
   assign memwb_flush = ctrl_gated.memwb_flush;

   assign halt        = (state_q == HALTED);
   assign stall_inc   = active && !ctrl.pc_en;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with 4-bit counters so saturation is reachable.
module tb_pipeline_control;
   import cpu_types_pkg::*;

   localparam int CNT_W = 4;

   localparam logic [8:0] C_ZERO   = 9'b0_0000_0000;
   localparam logic [8:0] C_FULL   = 9'b1_1111_0000;
   localparam logic [8:0] C_JUMP   = 9'b1_1111_1000;
   localparam logic [8:0] C_FREEZE = 9'b0_0001_0001;
   localparam logic [8:0] C_PART   = 9'b0_0011_0010;
   localparam logic [8:0] C_BRANCH = 9'b1_1111_1110;
   localparam logic [8:0] C_LU     = 9'b0_0111_0100;
   localparam logic [8:0] C_IFBUB  = 9'b0_1111_1000;

   logic CLK = 1'b0;
   logic nRST;
   logic ihit, dhit, mem_dren, mem_dwen, ex_dren, id_uses_rt;
   logic id_jump, id_halt, mem_brtaken, wb_halt;
   regbits_t ex_rt, id_rs, id_rt;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [8:0] ctl;

   int n_tests = 0;
   int n_fail  = 0;

   assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

   always #5 CLK = ~CLK;

   pipeline_control #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen), .ex_dren(ex_dren),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_halt(id_halt), .mem_brtaken(mem_brtaken),
      .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
      ex_dren = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
      id_jump = 1'b0; id_halt = 1'b0; mem_brtaken = 1'b0; wb_halt = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      nRST = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_ZERO) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_ZERO); end
      tick();
      n_tests++;
      if ({halt, stall_cnt, flush_cnt} !== 9'b0) begin
         n_fail++; $display("FAIL reset_regs: got halt=%b stall=%0d flush=%0d want 0", halt, stall_cnt, flush_cnt);
      end
      nRST = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL reset_run: got %b want %b", ctl, C_FULL); end
   endtask

   task automatic test_full_and_jump();
      do_reset();
      id_jump = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_JUMP) begin n_fail++; $display("FAIL jump: got %b want %b", ctl, C_JUMP); end
      tick();
      idle();
      tick();
      n_tests++;
      if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL full_stall: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_dren = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs: got %b want %b", ctl, C_LU); end
      tick();
      n_tests++;
      if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
      id_rs = 5'd5; id_rt = 5'd2;
      #1;
      n_tests++;
      if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rt: got %b want %b", ctl, C_LU); end
      tick();
      id_uses_rt = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", ctl, C_FULL); end
      tick();
      ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL lu_r0: got %b want %b", ctl, C_FULL); end
      tick();
      n_tests++;
      if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_total: got %0d want 2", stall_cnt); end
      ex_rt = 5'd7; id_rs = 5'd7; ihit = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_no_ihit: got %b want %b", ctl, C_LU); end
   endtask

   task automatic test_dmiss();
      do_reset();
      mem_dren = 1'b1; ihit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++;
         if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dmiss_freeze%0d: got %b want %b", i, ctl, C_FREEZE); end
         tick();
      end
      dhit = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_PART) begin n_fail++; $display("FAIL dmiss_partial: got %b want %b", ctl, C_PART); end
      tick();
      ihit = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL dmiss_full: got %b want %b", ctl, C_FULL); end
      tick();
      n_tests++;
      if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL dmiss_stall_cnt: got %0d want 5", stall_cnt); end
      mem_dren = 1'b0; mem_dwen = 1'b1; dhit = 1'b0; mem_brtaken = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dmiss_over_branch: got %b want %b", ctl, C_FREEZE); end
   endtask

   task automatic test_branch();
      do_reset();
      mem_brtaken = 1'b1; ihit = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch: got %b want %b", ctl, C_BRANCH); end
      tick();
      n_tests++;
      if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
      end
      ex_dren = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
      #1;
      n_tests++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch_over_lu: got %b want %b", ctl, C_BRANCH); end
      tick();
      n_tests++;
      if (flush_cnt !== 4'd2) begin n_fail++; $display("FAIL branch_cnt2: got %0d want 2", flush_cnt); end
   endtask

   task automatic test_halt();
      do_reset();
      id_halt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL halt_enter: got %b want %b", ctl, C_FULL); end
      tick();
      id_halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ihit = (i != 1);
         #1;
         n_tests++;
         if (ctl !== C_IFBUB) begin n_fail++; $display("FAIL drain%0d: got %b want %b", i, ctl, C_IFBUB); end
         tick();
      end
      ihit = 1'b1; wb_halt = 1'b1;
      #1;
      n_tests++;
      if (halt !== 1'b0 || stall_cnt !== 4'd3) begin
         n_fail++; $display("FAIL drain_pre_halt: got halt=%b stall=%0d want 0/3", halt, stall_cnt);
      end
      tick();
      wb_halt = 1'b0; mem_brtaken = 1'b1; id_halt = 1'b1;
      #1;
      n_tests++;
      if (halt !== 1'b1 || ctl !== C_ZERO) begin
         n_fail++; $display("FAIL halted: got halt=%b ctl=%b want 1/%b", halt, ctl, C_ZERO);
      end
      tick();
      tick();
      n_tests++;
      if (halt !== 1'b1 || stall_cnt !== 4'd4 || flush_cnt !== 4'd0) begin
         n_fail++; $display("FAIL halted_sticky: got halt=%b stall=%0d flush=%0d want 1/4/0", halt, stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_run_halt();
      do_reset();
      wb_halt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL || halt !== 1'b0) begin
         n_fail++; $display("FAIL run_wb_halt: got ctl=%b halt=%b want %b/0", ctl, halt, C_FULL);
      end
      tick();
      wb_halt = 1'b0;
      #1;
      n_tests++;
      if (halt !== 1'b1 || ctl !== C_ZERO) begin
         n_fail++; $display("FAIL run_halted: got halt=%b ctl=%b want 1/%b", halt, ctl, C_ZERO);
      end
   endtask

   task automatic test_wrong_path();
      do_reset();
      id_halt = 1'b1; id_jump = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_JUMP) begin n_fail++; $display("FAIL halt_jump: got %b want %b", ctl, C_JUMP); end
      tick();
      id_halt = 1'b0; id_jump = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_IFBUB) begin n_fail++; $display("FAIL halt_jump_drain: got %b want %b", ctl, C_IFBUB); end
      tick();
      mem_brtaken = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL wrong_path_branch: got %b want %b", ctl, C_BRANCH); end
      tick();
      mem_brtaken = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_FULL || flush_cnt !== 4'd1) begin
         n_fail++; $display("FAIL wrong_path_run: got ctl=%b flush=%0d want %b/1", ctl, flush_cnt, C_FULL);
      end
   endtask

   task automatic test_reset_sat();
      do_reset();
      id_halt = 1'b1;
      tick();
      id_halt = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      n_tests++;
      if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15: got %0d want 15", stall_cnt); end
      tick();
      n_tests++;
      if (stall_cnt !== 4'd15 || ctl !== C_IFBUB) begin
         n_fail++; $display("FAIL sat_hold: got stall=%0d ctl=%b want 15/%b", stall_cnt, ctl, C_IFBUB);
      end
      #2;
      nRST = 1'b0;
      #1;
      n_tests++;
      if (ctl !== C_ZERO || stall_cnt !== 4'd0 || halt !== 1'b0) begin
         n_fail++; $display("FAIL mid_drain_reset: got ctl=%b stall=%0d halt=%b want 0/0/0", ctl, stall_cnt, halt);
      end
      tick();
      nRST = 1'b1;
      #1;
      n_tests++;
      if (ctl !== C_FULL) begin n_fail++; $display("FAIL reset_to_run: got %b want %b", ctl, C_FULL); end
   endtask

   initial begin
      idle();
      nRST = 1'b0;
      test_reset();
      test_full_and_jump();
      test_load_use();
      test_dmiss();
      test_branch();
      test_halt();
      test_run_halt();
      test_wrong_path();
      test_reset_sat();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
